// File: rtl/pss_peak_detector.sv
// PSS peak detector: thresholds each magnitude against a scaled moving average, then
// searches a short window for the true maximum and reports it once before a hold-off.
module pss_peak_detector #(
   parameter int unsigned IN_DW           = 24,
   parameter int unsigned C_DW            = 72,
   parameter int unsigned WINDOW_LEN      = 8,
   parameter int unsigned DETECTION_SHIFT = 3,
   parameter int unsigned MIN_LEVEL       = 0,
   parameter int unsigned SEARCH_LEN      = 4,
   parameter int unsigned HOLDOFF_LEN     = 64,
   parameter int unsigned CNT_DW          = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [IN_DW-1:0]  s_axis_in_tdata,
   input  logic              s_axis_in_tvalid,
   input  logic [C_DW-1:0]   C0_i,
   input  logic [C_DW-1:0]   C1_i,
   output logic              peak_detected_o,
   output logic [CNT_DW-1:0] peak_pos_o,
   output logic [IN_DW-1:0]  peak_mag_o,
   output logic [C_DW-1:0]   C0_o,
   output logic [C_DW-1:0]   C1_o,
   output logic [1:0]        state_o
);

   localparam int unsigned LOG_W  = $clog2(WINDOW_LEN);
   localparam int unsigned SUM_W  = IN_DW + LOG_W;
   localparam int unsigned CMP_W  = IN_DW + LOG_W + DETECTION_SHIFT;
   localparam int unsigned FILL_W = $clog2(WINDOW_LEN + 1);
   localparam int unsigned SRCH_W = $clog2(SEARCH_LEN + 1);
   localparam int unsigned HOLD_W = (HOLDOFF_LEN < 2) ? 1 : $clog2(HOLDOFF_LEN + 1);
   localparam logic [IN_DW:0] MIN_EXT = (IN_DW + 1)'(MIN_LEVEL);

   typedef enum logic [1:0] {StIdle = 2'd0, StSearch = 2'd1, StHoldoff = 2'd2} state_e;

   state_e              state_q, state_d;
   logic [IN_DW-1:0]    hist_q [WINDOW_LEN];
   logic [LOG_W-1:0]    wr_ptr_q;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [CNT_DW-1:0]   idx_q, idx_d;
   logic [SRCH_W-1:0]   srch_q, srch_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_DW-1:0]   cand_pos_q, cand_pos_d;
   logic [IN_DW-1:0]    cand_mag_q, cand_mag_d;
   logic [C_DW-1:0]     cand_c0_q, cand_c0_d, cand_c1_q, cand_c1_d;
   logic                det_q, det_d;
   logic [CNT_DW-1:0]   pos_q, pos_d;
   logic [IN_DW-1:0]    mag_q, mag_d;
   logic [C_DW-1:0]     c0_q, c0_d, c1_q, c1_d;

   logic [CMP_W-1:0]    lhs, rhs;
   logic                above_min, warm, trigger, finish;

   // tdata*WINDOW_LEN vs S*2^DETECTION_SHIFT; S still excludes the current sample.
   assign lhs       = CMP_W'(s_axis_in_tdata) << LOG_W;
   assign rhs       = CMP_W'(sum_q) << DETECTION_SHIFT;
   assign above_min = ({1'b0, s_axis_in_tdata} + (IN_DW + 1)'(1)) > MIN_EXT;
   assign warm      = (fill_q == FILL_W'(WINDOW_LEN));
   assign trigger   = warm && (lhs > rhs) && above_min;

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      fill_d     = fill_q;
      idx_d      = idx_q;
      srch_d     = srch_q;
      hold_d     = hold_q;
      cand_pos_d = cand_pos_q;
      cand_mag_d = cand_mag_q;
      cand_c0_d  = cand_c0_q;
      cand_c1_d  = cand_c1_q;
      det_d      = 1'b0;
      pos_d      = pos_q;
      mag_d      = mag_q;
      c0_d       = c0_q;
      c1_d       = c1_q;
      finish     = 1'b0;
      if (s_axis_in_tvalid) begin
         idx_d = idx_q + CNT_DW'(1);
         sum_d = sum_q + SUM_W'(s_axis_in_tdata) - SUM_W'(hist_q[wr_ptr_q]);
         if (!warm) fill_d = fill_q + FILL_W'(1);
         unique case (state_q)
            StIdle: begin
               if (trigger) begin
                  cand_pos_d = idx_q;
                  cand_mag_d = s_axis_in_tdata;
                  cand_c0_d  = C0_i;
                  cand_c1_d  = C1_i;
                  srch_d     = SRCH_W'(1);
                  state_d    = StSearch;
                  finish     = (SEARCH_LEN == 1);
               end
            end
            StSearch: begin
               srch_d = srch_q + SRCH_W'(1);
               // Strictly greater only: ties keep the earliest sample.
               if (s_axis_in_tdata > cand_mag_q) begin
                  cand_pos_d = idx_q;
                  cand_mag_d = s_axis_in_tdata;
                  cand_c0_d  = C0_i;
                  cand_c1_d  = C1_i;
               end
               finish = (srch_d == SRCH_W'(SEARCH_LEN));
            end
            StHoldoff: begin
               hold_d = hold_q + HOLD_W'(1);
               if (hold_d == HOLD_W'(HOLDOFF_LEN)) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
         if (finish) begin
            det_d   = 1'b1;
            pos_d   = cand_pos_d;
            mag_d   = cand_mag_d;
            c0_d    = cand_c0_d;
            c1_d    = cand_c1_d;
            hold_d  = '0;
            state_d = (HOLDOFF_LEN == 0) ? StIdle : StHoldoff;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= StIdle;
         for (int i = 0; i < WINDOW_LEN; i++) hist_q[i] <= '0;
         wr_ptr_q   <= '0;
         sum_q      <= '0;
         fill_q     <= '0;
         idx_q      <= '0;
         srch_q     <= '0;
         hold_q     <= '0;
         cand_pos_q <= '0;
         cand_mag_q <= '0;
         cand_c0_q  <= '0;
         cand_c1_q  <= '0;
         det_q      <= 1'b0;
         pos_q      <= '0;
         mag_q      <= '0;
         c0_q       <= '0;
         c1_q       <= '0;
      end else begin
         if (s_axis_in_tvalid) begin
            hist_q[wr_ptr_q] <= s_axis_in_tdata;
            wr_ptr_q         <= wr_ptr_q + LOG_W'(1);
         end
         state_q    <= state_d;
         sum_q      <= sum_d;
         fill_q     <= fill_d;
         idx_q      <= idx_d;
         srch_q     <= srch_d;
         hold_q     <= hold_d;
         cand_pos_q <= cand_pos_d;
         cand_mag_q <= cand_mag_d;
         cand_c0_q  <= cand_c0_d;
         cand_c1_q  <= cand_c1_d;
         det_q      <= det_d;
         pos_q      <= pos_d;
         mag_q      <= mag_d;
         c0_q       <= c0_d;
         c1_q       <= c1_d;
      end
   end

   assign peak_detected_o = det_q;
   assign peak_pos_o      = pos_q;
   assign peak_mag_o      = mag_q;
   assign C0_o            = c0_q;
   assign C1_o            = c1_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_pss_peak_detector.sv
// Bench for pss_peak_detector: directed scenarios plus random traffic, checked every cycle
// against a window-scanning reference model of the detection rules.
module tb_pss_peak_detector;

   localparam int unsigned IN_DW = 24, C_DW = 72, WL = 8, DS = 3, MINL = 0;
   localparam int unsigned SL = 4, HL = 64, CNT_DW = 32;

   logic              clk = 1'b0;
   logic              reset_ni;
   logic [IN_DW-1:0]  tdata;
   logic              tvalid;
   logic [C_DW-1:0]   c0_in, c1_in;
   logic              peak_detected;
   logic [CNT_DW-1:0] peak_pos;
   logic [IN_DW-1:0]  peak_mag;
   logic [C_DW-1:0]   c0_out, c1_out;
   logic [1:0]        state;

   always #5 clk = ~clk;

   pss_peak_detector #(
      .IN_DW(IN_DW), .C_DW(C_DW), .WINDOW_LEN(WL), .DETECTION_SHIFT(DS),
      .MIN_LEVEL(MINL), .SEARCH_LEN(SL), .HOLDOFF_LEN(HL), .CNT_DW(CNT_DW)
   ) dut (
      .clk_i(clk), .reset_ni(reset_ni), .s_axis_in_tdata(tdata), .s_axis_in_tvalid(tvalid),
      .C0_i(c0_in), .C1_i(c1_in), .peak_detected_o(peak_detected), .peak_pos_o(peak_pos),
      .peak_mag_o(peak_mag), .C0_o(c0_out), .C1_o(c1_out), .state_o(state)
   );

   int errors = 0;
   int checks = 0;

   logic [IN_DW-1:0] mags[$];
   logic [C_DW-1:0]  c0s[$], c1s[$];

   // Model results per sample index: pulse after this sample, and state after it.
   bit e_end[];
   int e_st[];
   int e_best[];

   logic [CNT_DW-1:0] t_pos;
   logic [IN_DW-1:0]  t_mag;
   logic [C_DW-1:0]   t_c0, t_c1;
   int                t_st;

   function automatic logic [C_DW-1:0] rnd_c();
      return C_DW'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic chk(input string tag, input logic [C_DW-1:0] obs, input logic [C_DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_bg(input int n);
      mags.delete(); c0s.delete(); c1s.delete();
      for (int i = 0; i < n; i++) begin
         mags.push_back(IN_DW'(100));
         c0s.push_back(rnd_c());
         c1s.push_back(rnd_c());
      end
   endtask

   function automatic bit trig(input int i);
      longint s = 0;
      for (int j = i - WL; j < i; j++) s += longint'(mags[j]);
      return (longint'(mags[i]) * WL > s * (longint'(1) << DS)) && (mags[i] >= MINL);
   endfunction

   task automatic build_model();
      int n = mags.size();
      int elig = WL;
      int i = 0;
      e_end = new[n]; e_st = new[n]; e_best = new[n];
      for (int k = 0; k < n; k++) begin e_end[k] = 0; e_st[k] = 0; e_best[k] = 0; end
      while (i < n) begin
         if (i >= elig && trig(i)) begin
            int e = i + SL - 1;
            int best = i;
            for (int j = i + 1; j <= e && j < n; j++) if (mags[j] > mags[best]) best = j;
            for (int j = i; j < e && j < n; j++) e_st[j] = 1;
            for (int j = e; j < e + HL && j < n; j++) e_st[j] = 2;
            if (e < n) begin e_end[e] = 1; e_best[e] = best; end
            elig = i + SL + HL;
            i = e + 1;
         end else begin
            i++;
         end
      end
   endtask

   task automatic step_check(input bit was_valid, input int k);
      bit det_exp;
      @(posedge clk); #1;
      det_exp = 1'b0;
      if (was_valid) begin
         det_exp = e_end[k];
         t_st    = e_st[k];
         if (det_exp) begin
            t_pos = CNT_DW'(e_best[k]);
            t_mag = mags[e_best[k]];
            t_c0  = c0s[e_best[k]];
            t_c1  = c1s[e_best[k]];
         end
      end
      chk("det", C_DW'(peak_detected), C_DW'(det_exp));
      chk("state", C_DW'(state), C_DW'(t_st));
      chk("pos", C_DW'(peak_pos), C_DW'(t_pos));
      chk("mag", C_DW'(peak_mag), C_DW'(t_mag));
      chk("c0", c0_out, t_c0);
      chk("c1", c1_out, t_c1);
   endtask

   // gap_mode: 0 none, 1 an idle cycle between every sample, 2 random idles.
   task automatic run(input int gap_mode, input int n_max);
      int n = (n_max < mags.size()) ? n_max : mags.size();
      build_model();
      for (int k = 0; k < n; k++) begin
         if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(9) < 3)) begin
            tvalid = 1'b0;
            tdata  = IN_DW'($urandom());
            c0_in  = rnd_c();
            c1_in  = rnd_c();
            step_check(1'b0, 0);
         end
         tvalid = 1'b1;
         tdata  = mags[k];
         c0_in  = c0s[k];
         c1_in  = c1s[k];
         step_check(1'b1, k);
      end
      tvalid = 1'b0;
   endtask

   task automatic do_reset(input bit valid_during);
      reset_ni = 1'b0;
      tvalid   = valid_during;
      tdata    = IN_DW'(1000);
      c0_in    = rnd_c();
      c1_in    = rnd_c();
      repeat (2) @(posedge clk);
      #1;
      t_pos = '0; t_mag = '0; t_c0 = '0; t_c1 = '0; t_st = 0;
      chk("rst_det", C_DW'(peak_detected), '0);
      chk("rst_state", C_DW'(state), '0);
      chk("rst_pos", C_DW'(peak_pos), '0);
      chk("rst_mag", C_DW'(peak_mag), '0);
      chk("rst_c0", c0_out, '0);
      chk("rst_c1", c1_out, '0);
      reset_ni = 1'b1;
      tvalid   = 1'b0;
   endtask

   initial begin
      reset_ni = 1'b0; tvalid = 1'b0; tdata = '0; c0_in = '0; c1_in = '0;
      t_pos = '0; t_mag = '0; t_c0 = '0; t_c1 = '0; t_st = 0;

      // Constant background: never triggers.
      do_reset(1'b0);
      load_bg(200);
      run(0, 200);

      // Single impulse with known C0/C1.
      do_reset(1'b0);
      load_bg(40);
      mags[20] = IN_DW'(1000); c0s[20] = C_DW'(5); c1s[20] = C_DW'(7);
      run(0, 40);

      // Equality boundary: 800*8 == 100*8*8, not a trigger.
      do_reset(1'b0);
      load_bg(40);
      mags[20] = IN_DW'(800);
      run(0, 40);

      // Later larger peak wins, tie keeps the earlier one.
      do_reset(1'b0);
      load_bg(40);
      mags[20] = IN_DW'(900); mags[22] = IN_DW'(1200); mags[23] = IN_DW'(1200);
      run(0, 40);

      // Hold-off suppresses index 60; index 100 triggers again.
      do_reset(1'b0);
      load_bg(130);
      mags[20] = IN_DW'(1000); mags[60] = IN_DW'(1000); mags[100] = IN_DW'(1000);
      run(0, 130);

      // Impulse during warm-up is ignored.
      do_reset(1'b0);
      load_bg(40);
      mags[3] = IN_DW'(1000);
      run(0, 40);

      // Scenario with alternating idle cycles.
      do_reset(1'b0);
      load_bg(40);
      mags[20] = IN_DW'(1000); c0s[20] = C_DW'(5); c1s[20] = C_DW'(7);
      run(1, 40);

      // Reset mid-search, while a valid sample is presented: no pulse, index restarts.
      do_reset(1'b0);
      load_bg(40);
      mags[20] = IN_DW'(1000);
      run(0, 21);
      do_reset(1'b1);
      load_bg(40);
      mags[20] = IN_DW'(1000);
      run(0, 40);

      // Random magnitudes with sporadic spikes and random idle cycles.
      for (int r = 0; r < 3; r++) begin
         do_reset(1'b0);
         mags.delete(); c0s.delete(); c1s.delete();
         for (int i = 0; i < 500; i++) begin
            if ($urandom_range(19) == 0) mags.push_back(IN_DW'($urandom_range(5000, 300)));
            else mags.push_back(IN_DW'($urandom_range(140, 60)));
            c0s.push_back(rnd_c());
            c1s.push_back(rnd_c());
         end
         run(2, 500);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
